// File: rtl/seg_disp_if.sv
// Bundle between the display content producers and seg_disp_arbiter.
// Producer side (master): req, per-source digits/enables, blink mask.
// Arbiter side (slave): muxed x/aen/dp_en toward seg7, owner gnt, switch pulse sw.
interface seg_disp_if;
  logic [2:0]  req;
  logic [31:0] x0;
  logic [31:0] x1;
  logic [31:0] x2;
  logic [7:0]  aen0;
  logic [7:0]  aen1;
  logic [7:0]  aen2;
  logic [7:0]  dp0;
  logic [7:0]  dp1;
  logic [7:0]  dp2;
  logic [7:0]  blink1;
  logic [31:0] x;
  logic [7:0]  aen;
  logic [7:0]  dp_en;
  logic [2:0]  gnt;
  logic        sw;

  modport master (
    output req, x0, x1, x2, aen0, aen1, aen2, dp0, dp1, dp2, blink1,
    input  x, aen, dp_en, gnt, sw
  );

  modport slave (
    input  req, x0, x1, x2, aen0, aen1, aen2, dp0, dp1, dp2, blink1,
    output x, aen, dp_en, gnt, sw
  );
endinterface

// File: rtl/seg_disp_arbiter.sv
// Fixed-priority arbiter sharing the seg7 display path between three sources
// (2 = notification > 1 = set-mode > 0 = time) with a minimum-hold guard
// against preemption flicker and a blink mask for the set-mode digit.
// Ports:
//   clk  - system clock
//   clr  - synchronous active-high reset
//   bus  - seg_disp_if.slave: requests/source data in; x, aen, dp_en, gnt, sw out
// All outputs are registered; gnt and data move together on the same edge.
module seg_disp_arbiter #(
  parameter int unsigned MIN_HOLD   = 25_000_000,
  parameter int unsigned BLINK_HALF = 12_500_000
) (
  input  logic       clk,
  input  logic       clr,
  seg_disp_if.slave  bus
);

  localparam int unsigned HC_W = $clog2(MIN_HOLD + 1);
  localparam int unsigned BC_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    OWN2 = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [HC_W-1:0]   hc_q, hc_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic              phase_q, phase_d;
  logic [31:0]       x_q, x_d;
  logic [7:0]        aen_q, aen_d;
  logic [7:0]        dp_q, dp_d;
  logic [2:0]        gnt_q, gnt_d;
  logic              sw_q, sw_d;
  logic              hold_done;
  logic              chg;

  // Highest-priority asserted requester, IDLE if none.
  function automatic state_t top_req(input logic [2:0] r);
    if (r[2])      return OWN2;
    else if (r[1]) return OWN1;
    else if (r[0]) return OWN0;
    else           return IDLE;
  endfunction

  // Registers: state, counters and all outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      hc_q    <= '0;
      bc_q    <= '0;
      phase_q <= 1'b0;
      x_q     <= '0;
      aen_q   <= '0;
      dp_q    <= '0;
      gnt_q   <= '0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      bc_q    <= bc_d;
      phase_q <= phase_d;
      x_q     <= x_d;
      aen_q   <= aen_d;
      dp_q    <= dp_d;
      gnt_q   <= gnt_d;
      sw_q    <= sw_d;
    end
  end

  // Next state, counters and next output values.
  always_comb begin
    state_d   = state_q;
    hc_d      = hc_q;
    bc_d      = bc_q;
    phase_d   = phase_q;
    x_d       = x_q;
    aen_d     = '0;
    dp_d      = '0;
    gnt_d     = '0;
    hold_done = (hc_q == HC_W'(MIN_HOLD));

    // Owner drop ignores the hold; preemption by a higher source waits for it.
    unique case (state_q)
      IDLE: state_d = top_req(bus.req);
      OWN0: begin
        if (!bus.req[0])                        state_d = top_req(bus.req);
        else if ((|bus.req[2:1]) && hold_done)  state_d = top_req(bus.req);
      end
      OWN1: begin
        if (!bus.req[1])                        state_d = top_req(bus.req);
        else if (bus.req[2] && hold_done)       state_d = OWN2;
      end
      OWN2: begin
        if (!bus.req[2])                        state_d = top_req(bus.req);
      end
      default: state_d = IDLE;
    endcase

    chg = (state_d != state_q);

    // Hold counter restarts on every ownership change and saturates.
    if (chg)              hc_d = '0;
    else if (!hold_done)  hc_d = hc_q + HC_W'(1);

    // Blink phase restarts on every ownership change, so each grant opens "on".
    if (chg) begin
      bc_d    = '0;
      phase_d = 1'b0;
    end else if (bc_q == BC_W'(BLINK_HALF - 1)) begin
      bc_d    = '0;
      phase_d = ~phase_q;
    end else begin
      bc_d    = bc_q + BC_W'(1);
    end

    // Data follows the incoming owner live; phase_d keeps the mask aligned with gnt.
    unique case (state_d)
      OWN0: begin
        x_d   = bus.x0;
        aen_d = bus.aen0;
        dp_d  = bus.dp0;
        gnt_d = 3'b001;
      end
      OWN1: begin
        x_d   = bus.x1;
        aen_d = phase_d ? (bus.aen1 & ~bus.blink1) : bus.aen1;
        dp_d  = bus.dp1;
        gnt_d = 3'b010;
      end
      OWN2: begin
        x_d   = bus.x2;
        aen_d = bus.aen2;
        dp_d  = bus.dp2;
        gnt_d = 3'b100;
      end
      default: ;
    endcase

    sw_d = chg;
  end

  assign bus.x     = x_q;
  assign bus.aen   = aen_q;
  assign bus.dp_en = dp_q;
  assign bus.gnt   = gnt_q;
  assign bus.sw    = sw_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench for seg_disp_arbiter with MIN_HOLD=4, BLINK_HALF=3.
module tb_seg_disp_arbiter;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  seg_disp_if bus ();

  seg_disp_arbiter #(
    .MIN_HOLD   (4),
    .BLINK_HALF (3)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct {
    logic        clr;
    logic [2:0]  req;
    logic [31:0] x0;
    logic [2:0]  gnt;
    logic [31:0] x;
    logic [7:0]  aen;
    logic [7:0]  dp;
    logic        sw;
  } vec_t;

  localparam int NV = 34;
  vec_t tbl [NV];

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] X1 = 32'h1111_1111;
  localparam logic [31:0] X2 = 32'h2222_2222;
  localparam logic [31:0] XA = 32'h0012_3456;
  localparam logic [31:0] XB = 32'h0012_3457;

  function automatic vec_t mk(input logic c, input logic [2:0] r, input logic [31:0] xi,
                              input logic [2:0] g, input logic [31:0] ex,
                              input logic [7:0] ea, input logic [7:0] ed, input logic es);
    vec_t v;
    v.clr = c; v.req = r; v.x0 = xi;
    v.gnt = g; v.x = ex; v.aen = ea; v.dp = ed; v.sw = es;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [2:0] g, input logic [31:0] ex,
                         input logic [7:0] ea, input logic [7:0] ed, input logic es);
    chk("gnt",   idx, 32'(bus.gnt),   32'(g));
    chk("x",     idx, bus.x,          ex);
    chk("aen",   idx, 32'(bus.aen),   32'(ea));
    chk("dp_en", idx, 32'(bus.dp_en), 32'(ed));
    chk("sw",    idx, 32'(bus.sw),    32'(es));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with all requests pending, then notification wins on release.
    tbl[0]  = mk(1, 3'b111, 32'h0, 3'b000, 32'h0, 8'h00, 8'h00, 0);
    tbl[1]  = mk(0, 3'b111, 32'h0, 3'b100, X2,    8'h0F, 8'h80, 1);
    tbl[2]  = mk(0, 3'b111, 32'h0, 3'b100, X2,    8'h0F, 8'h80, 0);
    // Drop all: IDLE blanks aen/dp but holds x.
    tbl[3]  = mk(0, 3'b000, 32'h0, 3'b000, X2,    8'h00, 8'h00, 1);
    tbl[4]  = mk(0, 3'b000, 32'h0, 3'b000, X2,    8'h00, 8'h00, 0);
    // IDLE entry for time source, then live tracking and held preemption.
    tbl[5]  = mk(0, 3'b001, XA,    3'b001, XA,    8'hFF, 8'h14, 1);
    tbl[6]  = mk(0, 3'b101, XB,    3'b001, XB,    8'hFF, 8'h14, 0);
    tbl[7]  = mk(0, 3'b101, XB,    3'b001, XB,    8'hFF, 8'h14, 0);
    tbl[8]  = mk(0, 3'b101, XB,    3'b001, XB,    8'hFF, 8'h14, 0);
    tbl[9]  = mk(0, 3'b101, XB,    3'b001, XB,    8'hFF, 8'h14, 0);
    tbl[10] = mk(0, 3'b101, XB,    3'b100, X2,    8'h0F, 8'h80, 1);
    // Owner drop to set-mode despite fresh hold; blink 3 on / 3 off.
    tbl[11] = mk(0, 3'b011, XB,    3'b010, X1,    8'hFF, 8'h02, 1);
    tbl[12] = mk(0, 3'b011, XB,    3'b010, X1,    8'hFF, 8'h02, 0);
    tbl[13] = mk(0, 3'b011, XB,    3'b010, X1,    8'hFF, 8'h02, 0);
    tbl[14] = mk(0, 3'b011, XB,    3'b010, X1,    8'hFC, 8'h02, 0);
    tbl[15] = mk(0, 3'b011, XB,    3'b010, X1,    8'hFC, 8'h02, 0);
    tbl[16] = mk(0, 3'b011, XB,    3'b010, X1,    8'hFC, 8'h02, 0);
    tbl[17] = mk(0, 3'b011, XB,    3'b010, X1,    8'hFF, 8'h02, 0);
    tbl[18] = mk(0, 3'b011, XB,    3'b010, X1,    8'hFF, 8'h02, 0);
    tbl[19] = mk(0, 3'b011, XB,    3'b010, X1,    8'hFF, 8'h02, 0);
    tbl[20] = mk(0, 3'b011, XB,    3'b010, X1,    8'hFC, 8'h02, 0);
    // Release, regrant restarts blink in the on phase.
    tbl[21] = mk(0, 3'b000, XB,    3'b000, X1,    8'h00, 8'h00, 1);
    tbl[22] = mk(0, 3'b010, XB,    3'b010, X1,    8'hFF, 8'h02, 1);
    tbl[23] = mk(0, 3'b010, XB,    3'b010, X1,    8'hFF, 8'h02, 0);
    tbl[24] = mk(0, 3'b010, XB,    3'b010, X1,    8'hFF, 8'h02, 0);
    tbl[25] = mk(0, 3'b010, XB,    3'b010, X1,    8'hFC, 8'h02, 0);
    tbl[26] = mk(0, 3'b110, XB,    3'b010, X1,    8'hFC, 8'h02, 0);
    tbl[27] = mk(0, 3'b110, XB,    3'b100, X2,    8'h0F, 8'h80, 1);
    // Reset in the middle of a hold, notification granted straight after.
    tbl[28] = mk(0, 3'b001, XB,    3'b001, XB,    8'hFF, 8'h14, 1);
    tbl[29] = mk(0, 3'b101, XB,    3'b001, XB,    8'hFF, 8'h14, 0);
    tbl[30] = mk(0, 3'b101, XB,    3'b001, XB,    8'hFF, 8'h14, 0);
    tbl[31] = mk(1, 3'b101, XB,    3'b000, 32'h0, 8'h00, 8'h00, 0);
    tbl[32] = mk(0, 3'b101, XB,    3'b100, X2,    8'h0F, 8'h80, 1);
    tbl[33] = mk(0, 3'b101, XB,    3'b100, X2,    8'h0F, 8'h80, 0);

    clr        = 1'b1;
    bus.req    = 3'b000;
    bus.x0     = 32'h0;
    bus.x1     = X1;
    bus.x2     = X2;
    bus.aen0   = 8'hFF;
    bus.aen1   = 8'hFF;
    bus.aen2   = 8'h0F;
    bus.dp0    = 8'h14;
    bus.dp1    = 8'h02;
    bus.dp2    = 8'h80;
    bus.blink1 = 8'h03;

    for (int i = 0; i < NV; i++) begin
      clr     = tbl[i].clr;
      bus.req = tbl[i].req;
      bus.x0  = tbl[i].x0;
      tick();
      chk_all(i, tbl[i].gnt, tbl[i].x, tbl[i].aen, tbl[i].dp, tbl[i].sw);
    end

    // Owner 2 drops while 0 still requests: immediate switch.
    bus.req = 3'b001;
    tick();
    chk_all(100, 3'b001, XB, 8'hFF, 8'h14, 1'b1);

    // Owner 0 drops in the same cycle 1 and 2 rise: highest wins, no hold.
    bus.req = 3'b110;
    tick();
    chk_all(101, 3'b100, X2, 8'h0F, 8'h80, 1'b1);

    // Live tracking of the current owner's digits.
    bus.x2 = 32'hABCD_0123;
    tick();
    chk_all(102, 3'b100, 32'hABCD_0123, 8'h0F, 8'h80, 1'b0);

    // Lower-priority requesters never take the display from the top source.
    bus.req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_all(103 + k, 3'b100, 32'hABCD_0123, 8'h0F, 8'h80, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
